// File: rtl/cond_unit_mc.sv
// Multi-context ARM condition unit with NZCV banks and one outstanding multi-cycle op tracker.
// Build option: define COND_MC_FLAGS_EN to let multi-cycle ops load N,Z from M_Flags at completion.
module cond_unit_mc #(
  parameter int NUM_CTX    = 2,
  parameter int CTX_W      = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Valid,
  input  logic [CTX_W-1:0] CtxSel,
  input  logic [3:0]       Cond,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic [1:0]       FlagW,
  input  logic [3:0]       ALUFlags,
  input  logic             M_StartS,
  input  logic             M_Done,
  input  logic [1:0]       M_Flags,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             M_Start,
  output logic             Stall,
  output logic             McRegWrite,
  output logic             McErr,
  output logic [3:0]       Flags
);

  localparam int CNT_W = $clog2(MC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CTX_W-1:0] ctx_q;
  logic             flagw1_q;
  logic             regw_q;
  logic [3:0]       flags_q [NUM_CTX];
  logic [3:0]       flags_d [NUM_CTX];

  logic [3:0] bank;
  logic       ctx_ok;
  logic       cond_pass;
  logic       busy, issue, mc_done, mc_timeout;

  // Select the addressed bank; an out-of-range context reads as 0000 and never executes.
  always_comb begin
    bank   = '0;
    ctx_ok = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (CtxSel == CTX_W'(i)) begin
        bank   = flags_q[i];
        ctx_ok = 1'b1;
      end
    end
  end

  always_comb begin
    case (Cond)
      4'b0000: cond_pass = bank[2];
      4'b0001: cond_pass = ~bank[2];
      4'b0010: cond_pass = bank[1];
      4'b0011: cond_pass = ~bank[1];
      4'b0100: cond_pass = bank[3];
      4'b0101: cond_pass = ~bank[3];
      4'b0110: cond_pass = bank[0];
      4'b0111: cond_pass = ~bank[0];
      4'b1000: cond_pass = ~bank[2] & bank[1];
      4'b1001: cond_pass = bank[2] | ~bank[1];
      4'b1010: cond_pass = ~(bank[3] ^ bank[0]);
      4'b1011: cond_pass = bank[3] ^ bank[0];
      4'b1100: cond_pass = ~bank[2] & ~(bank[3] ^ bank[0]);
      4'b1101: cond_pass = bank[2] | (bank[3] ^ bank[0]);
      default: cond_pass = 1'b1;
    endcase
  end

  assign busy       = (state_q == BUSY);
  assign Stall      = busy & Valid;
  assign issue      = Valid & ~Stall & ctx_ok & cond_pass;
  assign mc_done    = busy & M_Done;
  assign mc_timeout = busy & ~M_Done & (cnt_q == CNT_LAST);

  assign PCSrc      = PCS & issue;
  assign MemWrite   = MemW & issue;
  assign RegWrite   = RegW & ~NoWrite & issue & ~M_StartS;
  assign M_Start    = M_StartS & issue;
  assign McRegWrite = mc_done & regw_q & ~RESET;
  assign McErr      = mc_timeout & ~RESET;
  assign Flags      = bank;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    for (int i = 0; i < NUM_CTX; i++) flags_d[i] = flags_q[i];
    if (issue & ~M_StartS) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (CtxSel == CTX_W'(i)) begin
          if (FlagW[1]) flags_d[i][3:2] = ALUFlags[3:2];
          if (FlagW[0]) flags_d[i][1:0] = ALUFlags[1:0];
        end
      end
    end
`ifdef COND_MC_FLAGS_EN
    // Completion can never coincide with an issue, since BUSY holds every instruction.
    if (mc_done & flagw1_q) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (ctx_q == CTX_W'(i)) flags_d[i][3:2] = M_Flags;
      end
    end
`endif
  end

`ifndef COND_MC_FLAGS_EN
  logic unused_mc_flags;
  assign unused_mc_flags = ^{M_Flags, flagw1_q, ctx_q};
`endif

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctx_q    <= '0;
      flagw1_q <= 1'b0;
      regw_q   <= 1'b0;
      // NOTE: the flag banks are architectural state that must read 0000 after reset, so they are reset.
      flags_q  <= '{default: '0};
    end else begin
      flags_q <= flags_d;
      case (state_q)
        IDLE: begin
          if (M_Start) begin
            state_q  <= BUSY;
            cnt_q    <= '0;
            ctx_q    <= CtxSel;
            flagw1_q <= FlagW[1];
            regw_q   <= RegW & ~NoWrite;
          end
        end
        BUSY: begin
          if (M_Done || cnt_q == CNT_LAST) state_q <= IDLE;
          else                             cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Randomized self-checking bench for cond_unit_mc against a cycle-level behavioural model.
module tb_cond_unit_mc;

  localparam int NUM_CTX    = 2;
  localparam int CTX_W      = 2;
  localparam int MC_TIMEOUT = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             Valid;
  logic [CTX_W-1:0] CtxSel;
  logic [3:0]       Cond;
  logic             PCS, RegW, MemW, NoWrite;
  logic [1:0]       FlagW;
  logic [3:0]       ALUFlags;
  logic             M_StartS, M_Done;
  logic [1:0]       M_Flags;
  logic             PCSrc, RegWrite, MemWrite, M_Start, Stall, McRegWrite, McErr;
  logic [3:0]       Flags;

  cond_unit_mc #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .Valid(Valid), .CtxSel(CtxSel), .Cond(Cond),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
    .ALUFlags(ALUFlags), .M_StartS(M_StartS), .M_Done(M_Done), .M_Flags(M_Flags),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .M_Start(M_Start),
    .Stall(Stall), .McRegWrite(McRegWrite), .McErr(McErr), .Flags(Flags)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: flag banks plus a record of the one op in flight.
  logic [3:0] m_flags [NUM_CTX];
  bit         m_busy;
  int         m_age;
  int         m_ctx;
  bit         m_wreg;
`ifdef COND_MC_FLAGS_EN
  bit         m_wnz;
`endif

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return !z && cy;
      4'd9:  return z || !cy;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Called just after a falling edge with inputs applied; checks, advances the model, waits one cycle.
  task automatic step(input string tag);
    logic [3:0]  bank;
    bit          ok, stall, issue, done, tmo;
    logic [10:0] exp_v, obs_v;
    int          c;
    #1;
    c    = int'(CtxSel);
    ok   = c < NUM_CTX;
    bank = 4'b0000;
    if (ok) bank = m_flags[c];
    stall = m_busy && Valid;
    issue = Valid && !stall && ok && cond_holds(Cond, bank);
    done  = m_busy && M_Done;
    tmo   = m_busy && !M_Done && (m_age == MC_TIMEOUT);
    exp_v = {PCS && issue, RegW && !NoWrite && issue && !M_StartS, MemW && issue,
             M_StartS && issue, stall, done && m_wreg && !RESET, tmo && !RESET, bank};
    obs_v = {PCSrc, RegWrite, MemWrite, M_Start, Stall, McRegWrite, McErr, Flags};
    check(tag, 32'(obs_v), 32'(exp_v));
    if (RESET) begin
      for (int i = 0; i < NUM_CTX; i++) m_flags[i] = 4'b0000;
      m_busy = 1'b0;
      m_age  = 0;
    end else begin
      if (issue && !M_StartS) begin
        if (FlagW[1]) m_flags[c][3:2] = ALUFlags[3:2];
        if (FlagW[0]) m_flags[c][1:0] = ALUFlags[1:0];
      end
      if (done) begin
`ifdef COND_MC_FLAGS_EN
        if (m_wnz) m_flags[m_ctx][3:2] = M_Flags;
`endif
        m_busy = 1'b0;
      end else if (tmo) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
      if (issue && M_StartS) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_ctx  = c;
        m_wreg = RegW && !NoWrite;
`ifdef COND_MC_FLAGS_EN
        m_wnz  = FlagW[1];
`endif
      end
    end
    @(negedge CLK);
  endtask

  task automatic cyc(input string tag, input logic v, input logic [1:0] ctx, input logic [3:0] c,
                     input logic pcs, input logic regw, input logic memw, input logic nowr,
                     input logic [1:0] fw, input logic [3:0] alu, input logic ms,
                     input logic md, input logic [1:0] mf);
    Valid = v; CtxSel = ctx; Cond = c; PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
    FlagW = fw; ALUFlags = alu; M_StartS = ms; M_Done = md; M_Flags = mf;
    step(tag);
  endtask

  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, AL = 4'd14;

  initial begin
    for (int i = 0; i < NUM_CTX; i++) m_flags[i] = 4'b0000;
    m_busy = 1'b0; m_age = 0; m_ctx = 0; m_wreg = 1'b0;
`ifdef COND_MC_FLAGS_EN
    m_wnz = 1'b0;
`endif
    RESET = 1'b1;
    Valid = 0; CtxSel = 0; Cond = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    FlagW = 0; ALUFlags = 0; M_StartS = 0; M_Done = 0; M_Flags = 0;
    @(negedge CLK);
    cyc("reset", 0, 0, EQ, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    RESET = 1'b0;
    check("reset_flags", 32'(Flags), 32'h0);

    // Z=0 after reset, so EQ fails; SUBS sets Z; EQ then branches.
    cyc("eq_after_reset", 1, 0, EQ, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    check("eq_after_reset_pcsrc", 32'(PCSrc), 32'h0);
    cyc("subs", 1, 0, AL, 0, 1, 0, 1, 2'b11, 4'b0100, 0, 0, 2'b00);
    check("subs_flags", 32'(Flags), 32'h4);
    cyc("eq_taken", 1, 0, EQ, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);

    // Bank isolation and out-of-range context.
    cyc("ctx0_clear", 1, 0, AL, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 2'b00);
    cyc("ctx1_setz", 1, 1, AL, 0, 0, 0, 0, 2'b10, 4'b0100, 0, 0, 2'b00);
    cyc("eq_ctx0", 1, 0, EQ, 1, 1, 1, 0, 2'b11, 4'b1111, 0, 0, 2'b00);
    check("ctx0_unchanged", 32'(Flags), 32'h0);
    cyc("eq_ctx1", 1, 1, EQ, 1, 1, 1, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    cyc("ctx2_suppressed", 1, 2, AL, 1, 1, 1, 0, 2'b11, 4'b1111, 1, 0, 2'b00);

    // MULS on ctx0 with C,V set; completion in the third BUSY cycle.
    cyc("mul_prep", 1, 0, AL, 0, 0, 0, 0, 2'b11, 4'b0011, 0, 0, 2'b00);
    cyc("mul_issue", 1, 0, AL, 0, 1, 0, 0, 2'b10, 4'b1111, 1, 0, 2'b00);
    cyc("mul_busy1", 1, 0, AL, 1, 1, 1, 0, 2'b11, 4'b1111, 0, 0, 2'b00);
    cyc("mul_busy2", 1, 0, EQ, 1, 1, 1, 0, 2'b11, 4'b1111, 0, 0, 2'b00);
    cyc("mul_done", 1, 0, AL, 1, 1, 1, 0, 2'b11, 4'b1111, 0, 1, 2'b10);
`ifdef COND_MC_FLAGS_EN
    check("mul_flags", 32'(Flags), 32'hB);
`else
    check("mul_flags", 32'(Flags), 32'h3);
`endif
    cyc("mul_next", 1, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);

    // MULNE with Z=1 never starts.
    cyc("setz", 1, 0, AL, 0, 0, 0, 0, 2'b10, 4'b0100, 0, 0, 2'b00);
    cyc("mulne_issue", 1, 0, NE, 0, 1, 0, 0, 2'b10, 4'h0, 1, 0, 2'b00);
    cyc("mulne_after", 1, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    check("mulne_stall", 32'(Stall), 32'h0);

    // Timeout: four BUSY cycles without M_Done, then a late M_Done.
    cyc("to_issue", 1, 0, AL, 0, 1, 0, 0, 2'b10, 4'h0, 1, 0, 2'b00);
    for (int i = 0; i < MC_TIMEOUT; i++)
      cyc("to_busy", 1, 0, AL, 0, 1, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    cyc("to_late_done", 0, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 2'b01);

    // RESET in the second BUSY cycle drops the op and clears the flags.
    cyc("rb_issue", 1, 0, AL, 0, 1, 0, 0, 2'b10, 4'h0, 1, 0, 2'b00);
    cyc("rb_busy1", 1, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 2'b00);
    RESET = 1'b1;
    cyc("rb_busy2_reset", 1, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 2'b11);
    RESET = 1'b0;
    cyc("rb_late_done", 0, 0, AL, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 2'b11);
    check("rb_flags", 32'(Flags), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      RESET = ($urandom_range(199) == 0);
      cyc("random", $urandom_range(9) < 8, 2'($urandom_range(3)), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
          2'($urandom), 4'($urandom), ($urandom_range(5) == 0),
          ($urandom_range(4) == 0), 2'($urandom));
    end
    RESET = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
